uart_stream_ctrl: RTL and testbench
===================================

UART_STREAM_CTRL -- requirements
Module: uart_stream_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): CSR_ADDR_W, 4, CSR address width; CSR_DATA_W, 32, CSR data width; FIFO_DEPTH, 4, TX FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameters for CSR addresses: ADDR_CTRL, 0; ADDR_STATUS, 1; ADDR_TXDATA, 2; ADDR_RXDATA, 3.
REQ-003 SHALL have ports (name, direction, width, meaning): clk, in, 1, the single clock; rst_n, in, 1, asynchronous active-low reset.
REQ-004 SHALL have ports: tx_data, in, 8, byte to send; tx_valid, in, 1; tx_ready, out, 1, asserted when the TX FIFO is not full.
REQ-005 SHALL have ports: rx_data, out, 8, received byte; rx_valid, out, 1; rx_ready, in, 1.
REQ-006 SHALL have ports: csr_wr_addr, out, CSR_ADDR_W; csr_wr_data, out, CSR_DATA_W; csr_wen, out, 1; csr_rd_addr, out, CSR_ADDR_W; csr_ren, out, 1; csr_rd_data, in, CSR_DATA_W, valid the cycle after csr_ren.
REQ-007 SHALL have ports: parity_err, out, 1, sticky flag; parity_err_cnt, out, 8, saturating count of parity errors.

Function
REQ-008 SHALL decode STATUS bits as: [0] busy, [1] data_sent, [2] rx_data_valid, [3] parity_error. Writing CTRL bit0 = 1 starts transmission; reading RXDATA clears rx_data_valid in the UART.
REQ-009 SHALL accept a byte on tx_valid && tx_ready into the FIFO, using wrap-around pointers and a count with FIFO_DEPTH entries.
REQ-010 SHALL support a simultaneous push and pop when the FIFO is full: the pop frees the entry, and tx_ready stays low that cycle because it is registered from the count.
REQ-011 SHALL sequence the CSR port with the FSM states IDLE, ST_RD, ST_CAP, TX_WR, TX_GO, TXW_RD, TXW_CAP, RX_RD, RX_CAP, RX_OUT.
REQ-012 IDLE SHALL go to ST_RD every cycle that rx_valid is 0.
REQ-013 ST_RD SHALL assert csr_ren with csr_rd_addr = ADDR_STATUS for one cycle, then go to ST_CAP.
REQ-014 ST_CAP SHALL choose the next state as follows:
- rx_data_valid = 1 -> RX_RD (RX has priority to avoid overrun);
- otherwise, FIFO non-empty and busy = 0 -> TX_WR;
- otherwise -> IDLE.
REQ-015 TX_WR SHALL write the FIFO head, zero-extended, to ADDR_TXDATA with csr_wen for one cycle, and pop the FIFO.
REQ-016 TX_GO SHALL write 1 to ADDR_CTRL for one cycle.
REQ-017 TXW_RD and TXW_CAP SHALL poll STATUS until data_sent = 1, then return to IDLE. TX_WR through data_sent is never interrupted by RX.
REQ-018 RX_RD SHALL read ADDR_RXDATA. RX_CAP SHALL latch csr_rd_data[7:0] into rx_data, set rx_valid, and go to RX_OUT.
REQ-019 RX_OUT SHALL hold rx_data and rx_valid stable until rx_ready; on the handshake it SHALL clear rx_valid and go to IDLE.
REQ-020 SHALL drive csr_wen and csr_ren for at most one cycle each, never both in the same cycle. Address and data outputs SHALL be 0 when the corresponding enable is 0.
REQ-021 On any status capture with parity_error = 1, SHALL set parity_err and increment parity_err_cnt, saturating at 255.
REQ-022 SHALL keep parity_err sticky until reset.

Reset
REQ-023 While rst_n = 0 (asynchronous), SHALL hold:
- FSM in IDLE;
- FIFO empty;
- tx_ready 0, rising to 1 the first cycle after reset release;
- rx_valid 0, rx_data 0;
- all CSR outputs 0;
- parity_err 0, parity_err_cnt 0.
REQ-024 Reset mid-transaction SHALL discard FIFO contents and any pending RX byte with no further CSR access.

Verification
REQ-025 Single TX: push 0x5A, status returns busy = 0 -> write TXDATA = 0x5A, next cycle CTRL = 1, then STATUS polls until data_sent = 1, then IDLE.
REQ-026 FIFO full: push 4 bytes with busy held at 1 -> tx_ready = 0 and a 5th push is ignored; release busy -> bytes go out in order 1 through 4, and tx_ready returns to 1.
REQ-027 RX priority: FIFO non-empty and status = 0x4 -> RXDATA read first, returning 0xA3 -> rx_data = 0xA3 with rx_valid held until rx_ready, then the TX byte is sent.
REQ-028 Parity: 300 status captures with bit3 = 1 -> parity_err = 1, parity_err_cnt = 255.
REQ-029 Reset mid-TX: assert rst_n = 0 during TXW_CAP with 2 bytes queued -> outputs take reset values immediately, and no CSR writes occur after release.
REQ-030 Backpressure: rx_ready = 0 for 10 cycles -> no CSR reads during RX_OUT, and rx_data is stable.

Source files
------------

// File: rtl/uart_stream_ctrl.sv
// Bridges a byte stream to a register-mapped UART: queues TX bytes, polls STATUS,
// writes TXDATA/CTRL, and forwards received bytes with a valid/ready handshake.
module uart_stream_ctrl #(
    parameter int                    CSR_ADDR_W  = 4,
    parameter int                    CSR_DATA_W  = 32,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [CSR_ADDR_W-1:0] ADDR_CTRL   = 0,
    parameter logic [CSR_ADDR_W-1:0] ADDR_STATUS = 1,
    parameter logic [CSR_ADDR_W-1:0] ADDR_TXDATA = 2,
    parameter logic [CSR_ADDR_W-1:0] ADDR_RXDATA = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [CSR_ADDR_W-1:0] csr_wr_addr,
    output logic [CSR_DATA_W-1:0] csr_wr_data,
    output logic                  csr_wen,
    output logic [CSR_ADDR_W-1:0] csr_rd_addr,
    output logic                  csr_ren,
    input  logic [CSR_DATA_W-1:0] csr_rd_data,
    output logic                  parity_err,
    output logic [7:0]            parity_err_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [PTR_W-1:0]      PTR_ONE    = 1;
    localparam logic [PTR_W:0]        CNT_ONE    = 1;
    localparam logic [PTR_W:0]        CNT_ZERO   = 0;
    localparam logic [PTR_W:0]        CNT_FULL   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CSR_DATA_W-1:0] CTRL_START = 1;

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] ST_RD   = 4'd1;
    localparam logic [3:0] ST_CAP  = 4'd2;
    localparam logic [3:0] TX_WR   = 4'd3;
    localparam logic [3:0] TX_GO   = 4'd4;
    localparam logic [3:0] TXW_RD  = 4'd5;
    localparam logic [3:0] TXW_CAP = 4'd6;
    localparam logic [3:0] RX_RD   = 4'd7;
    localparam logic [3:0] RX_CAP  = 4'd8;
    localparam logic [3:0] RX_OUT  = 4'd9;

    logic [3:0]       state_reg, state_next;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic             tx_ready_reg;
    logic [7:0]       rx_data_reg;
    logic             rx_valid_reg;
    logic             parity_err_reg;
    logic [7:0]       parity_cnt_reg;

    logic push, pop;
    logic sts_busy, sts_sent, sts_rx_valid, sts_parity;
    logic status_cap;
    logic unused_rd_bits;

    assign sts_busy     = csr_rd_data[0];
    assign sts_sent     = csr_rd_data[1];
    assign sts_rx_valid = csr_rd_data[2];
    assign sts_parity   = csr_rd_data[3];
    assign unused_rd_bits = ^csr_rd_data[CSR_DATA_W-1:8];

    assign push       = tx_valid && tx_ready_reg;
    // Only TX_WR pops, and it is entered only with a non-empty FIFO.
    assign pop        = (state_reg == TX_WR);
    assign status_cap = (state_reg == ST_CAP) || (state_reg == TXW_CAP);

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_ONE;
        end else if (!push && pop) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            tx_ready_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
            // Registered from the next count, so a pop while full does not admit a push that cycle.
            tx_ready_reg <= (count_next != CNT_FULL);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!rx_valid_reg) state_next = ST_RD;
            ST_RD:   state_next = ST_CAP;
            ST_CAP: begin
                if (sts_rx_valid) begin
                    state_next = RX_RD;
                end else if ((count_reg != CNT_ZERO) && !sts_busy) begin
                    state_next = TX_WR;
                end else begin
                    state_next = IDLE;
                end
            end
            TX_WR:   state_next = TX_GO;
            TX_GO:   state_next = TXW_RD;
            TXW_RD:  state_next = TXW_CAP;
            TXW_CAP: state_next = sts_sent ? IDLE : TXW_RD;
            RX_RD:   state_next = RX_CAP;
            RX_CAP:  state_next = RX_OUT;
            RX_OUT:  if (rx_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
            parity_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == RX_CAP) begin
                rx_data_reg  <= csr_rd_data[7:0];
                rx_valid_reg <= 1'b1;
            end else if ((state_reg == RX_OUT) && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
            if (status_cap && sts_parity) begin
                parity_err_reg <= 1'b1;
                if (parity_cnt_reg != 8'hFF) begin
                    parity_cnt_reg <= parity_cnt_reg + 8'd1;
                end
            end
        end
    end

    // CSR strobes decode straight from the state, so each access lasts exactly one state.
    always_comb begin
        csr_wen     = 1'b0;
        csr_wr_addr = '0;
        csr_wr_data = '0;
        csr_ren     = 1'b0;
        csr_rd_addr = '0;
        case (state_reg)
            ST_RD, TXW_RD: begin
                csr_ren     = 1'b1;
                csr_rd_addr = ADDR_STATUS;
            end
            RX_RD: begin
                csr_ren     = 1'b1;
                csr_rd_addr = ADDR_RXDATA;
            end
            TX_WR: begin
                csr_wen     = 1'b1;
                csr_wr_addr = ADDR_TXDATA;
                csr_wr_data = {{(CSR_DATA_W-8){1'b0}}, fifo_mem[rd_ptr_reg]};
            end
            TX_GO: begin
                csr_wen     = 1'b1;
                csr_wr_addr = ADDR_CTRL;
                csr_wr_data = CTRL_START;
            end
            default: begin
            end
        endcase
    end

    assign tx_ready       = tx_ready_reg;
    assign rx_data        = rx_data_reg;
    assign rx_valid       = rx_valid_reg;
    assign parity_err     = parity_err_reg;
    assign parity_err_cnt = parity_cnt_reg;

endmodule

// File: tb/tb_uart_stream_ctrl.sv
// Directed bench for uart_stream_ctrl with a small behavioural UART register model.
module tb_uart_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [3:0]  csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        csr_wen;
    logic [3:0]  csr_rd_addr;
    logic        csr_ren;
    logic [31:0] csr_rd_data = '0;
    logic        parity_err;
    logic [7:0]  parity_err_cnt;

    always #5 clk = ~clk;

    uart_stream_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .csr_wr_addr    (csr_wr_addr),
        .csr_wr_data    (csr_wr_data),
        .csr_wen        (csr_wen),
        .csr_rd_addr    (csr_rd_addr),
        .csr_ren        (csr_ren),
        .csr_rd_data    (csr_rd_data),
        .parity_err     (parity_err),
        .parity_err_cnt (parity_err_cnt)
    );

    // UART model controls
    logic       busy_hold = 1'b0;
    logic       par_bit   = 1'b0;
    logic [7:0] rx_byte   = 8'h00;
    int         rx_req    = 0;
    int         rx_ack    = 0;
    int         poll_left = 0;
    int         par_reads = 0;
    int         rd_in_rxout = 0;
    int         viol      = 0;
    int         cyc       = 0;
    int         wa[$];
    int         wd[$];
    int         wc[$];
    logic       rxdv;

    int n_checks = 0;
    int n_pass   = 0;

    assign rxdv = (rx_req != rx_ack);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (csr_ren) begin
            if (csr_rd_addr == 4'd1) begin
                csr_rd_data <= {28'd0, par_bit, rxdv, (poll_left == 0), busy_hold};
                if (poll_left != 0) poll_left <= poll_left - 1;
                if (par_bit) par_reads <= par_reads + 1;
            end else if (csr_rd_addr == 4'd3) begin
                csr_rd_data <= {24'd0, rx_byte};
                rx_ack <= rx_ack + 1;
            end else begin
                csr_rd_data <= '0;
            end
            if (rx_valid) rd_in_rxout <= rd_in_rxout + 1;
        end
        if (csr_wen) begin
            wa.push_back(int'(csr_wr_addr));
            wd.push_back(int'(csr_wr_data));
            wc.push_back(cyc);
            $display("[%0d] csr write addr=%0d data=0x%0h", cyc, csr_wr_addr, csr_wr_data);
            if (csr_wr_addr == 4'd0 && csr_wr_data[0]) poll_left <= 2;
        end
        if (rx_valid && rx_ready) $display("[%0d] rx byte delivered 0x%0h", cyc, rx_data);
        if (rst_n && ((csr_wen && csr_ren) ||
                      (!csr_wen && (csr_wr_addr != 0 || csr_wr_data != 0)) ||
                      (!csr_ren && csr_rd_addr != 0)))
            viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push1(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        $display("[%0d] push 0x%0h (tx_ready was sampled by DUT)", cyc, b);
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (wa.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_writes", wa.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b0;

        // Reset state
        idle(3);
        check("rst_tx_ready", 32'(tx_ready), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_csr_wen", 32'(csr_wen), 0);
        check("rst_csr_ren", 32'(csr_ren), 0);
        check("rst_parity_err", 32'(parity_err), 0);
        check("rst_parity_cnt", 32'(parity_err_cnt), 0);
        rst_n = 1'b1;
        #1;
        check("tx_ready_before_edge", 32'(tx_ready), 0);
        @(posedge clk);
        #1;
        check("tx_ready_after_release", 32'(tx_ready), 1);

        // Single TX
        push1(8'h5A);
        wait_writes(2, 60);
        check("tx1_addr", wa[0], 2);
        check("tx1_data", wd[0], 'h5A);
        check("tx1_ctrl_addr", wa[1], 0);
        check("tx1_ctrl_data", wd[1], 1);
        check("tx1_ctrl_next_cycle", wc[1] - wc[0], 1);
        idle(30);
        check("tx1_polls_done", poll_left, 0);
        check("tx1_no_extra", wa.size(), 2);

        // FIFO full while UART busy
        busy_hold = 1'b1;
        for (int b = 1; b <= 4; b++) push1(8'(b));
        check("full_tx_ready", 32'(tx_ready), 0);
        push1(8'h55);
        idle(20);
        check("busy_blocks_tx", wa.size(), 2);
        busy_hold = 1'b0;
        wait_writes(10, 300);
        for (int i = 0; i < 4; i++) begin
            check("full_order_addr", wa[2 + 2*i], 2);
            check("full_order_data", wd[2 + 2*i], i + 1);
            check("full_order_ctrl", wa[3 + 2*i], 0);
        end
        check("full_tx_ready_back", 32'(tx_ready), 1);
        idle(20);
        check("fifth_push_dropped", wa.size(), 10);

        // RX priority and backpressure
        busy_hold = 1'b1;
        push1(8'h77);
        idle(5);
        rx_byte   = 8'hA3;
        rx_req    = rx_req + 1;
        busy_hold = 1'b0;
        k = 0;
        while (!rx_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rx_valid_rise", 32'(rx_valid), 1);
        check("rx_data_value", 32'(rx_data), 'hA3);
        check("rx_before_tx", wa.size(), 10);
        k = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rx_valid || rx_data != 8'hA3) k++;
        end
        check("rx_hold_unstable_cycles", k, 0);
        check("rx_no_reads_during_out", rd_in_rxout, 0);
        check("rx_no_writes_during_out", wa.size(), 10);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("rx_handshake_clears", 32'(rx_valid), 0);
        check("rxdata_reads", rx_ack, 1);
        wait_writes(12, 60);
        check("rx_then_tx_addr", wa[10], 2);
        check("rx_then_tx_data", wd[10], 'h77);
        check("rx_then_tx_ctrl", wa[11], 0);

        // Parity counting and saturation
        idle(20);
        par_bit = 1'b1;
        k = 0;
        while (par_reads < 5 && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("parity_cnt_5", 32'(parity_err_cnt), 5);
        check("parity_err_set", 32'(parity_err), 1);
        k = 0;
        while (par_reads < 300 && k < 1500) begin
            @(negedge clk);
            k++;
        end
        check("parity_reads_300", 32'(par_reads >= 300), 1);
        par_bit = 1'b0;
        idle(10);
        check("parity_cnt_sat", 32'(parity_err_cnt), 255);
        idle(10);
        check("parity_err_sticky", 32'(parity_err), 1);

        // Reset in the middle of a TX poll with two bytes still queued
        busy_hold = 1'b1;
        push1(8'h11);
        push1(8'h22);
        push1(8'h33);
        busy_hold = 1'b0;
        wait_writes(14, 60);
        k = 0;
        while (!csr_ren && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_ready", 32'(tx_ready), 0);
        check("midrst_csr_wen", 32'(csr_wen), 0);
        check("midrst_csr_ren", 32'(csr_ren), 0);
        check("midrst_parity_err", 32'(parity_err), 0);
        check("midrst_parity_cnt", 32'(parity_err_cnt), 0);
        idle(3);
        rst_n = 1'b1;
        idle(100);
        check("midrst_no_writes_after", wa.size(), 14);
        check("midrst_tx_ready_back", 32'(tx_ready), 1);

        check("csr_protocol_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
